// File: rtl/sdram_ctrl_if.sv
// sdram_ctrl_if: request/response port between a bus master and sdram_core.
//
// Signals:
//   addr       - byte address of the request
//   write_data - write payload
//   wr         - per-byte write enables; any set bit makes a write request
//   rd         - read request
//   rdy        - controller accepts the pending request at this edge
//   rvalid     - read_data carries the response to the last accepted read
//   read_data  - read response payload
//
// Modports: man (request master), sub (controller side).
interface sdram_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   write_data;
    logic [DATA_WIDTH/8-1:0] wr;
    logic                    rd;
    logic                    rdy;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   read_data;

    modport man (
        output addr, write_data, wr, rd,
        input  rdy, rvalid, read_data
    );

    modport sub (
        input  addr, write_data, wr, rd,
        output rdy, rvalid, read_data
    );
endinterface

// File: rtl/sdram_bist.sv
// sdram_bist: built-in self-test master for sdram_core.
//
// On start, writes an address-derived pattern over a word-aligned range,
// reads it back, compares every word and reports the result.
//
// Ports:
//   clk, rst        - clock; synchronous active-high reset
//   start           - begin a test (only honoured while idle)
//   base_addr       - first byte address (forced to word alignment)
//   word_count      - number of words to test
//   pattern_sel     - 0: addr, 1: ~addr, 2: walking one, 3: addr ^ SEED
//   busy            - a test is running
//   done            - one-cycle completion pulse
//   pass            - test result, valid from done until the next start
//   err_count       - miscompares plus read timeouts (saturating)
//   first_err_addr  - address of the first failing word
//   first_err_data  - data read at the first failure (0 on timeout)
//   timeout         - sticky: some read never returned rvalid
//   ctrl            - controller request port (man side)
module sdram_bist #(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int          COUNT_WIDTH = 16,
    parameter int          ERR_WIDTH   = 16,
    parameter logic [31:0] SEED        = 32'hA5A5_5A5A,
    parameter int          RD_TIMEOUT  = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [COUNT_WIDTH-1:0] word_count,
    input  logic [1:0]             pattern_sel,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [ERR_WIDTH-1:0]   err_count,
    output logic [ADDR_WIDTH-1:0]  first_err_addr,
    output logic [DATA_WIDTH-1:0]  first_err_data,
    output logic                   timeout,
    sdram_ctrl_if.man              ctrl
);

    localparam int STRIDE    = DATA_WIDTH / 8;
    localparam int TMR_WIDTH = $clog2(RD_TIMEOUT + 1);

    localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(STRIDE);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRIDE - 1);
    localparam logic [DATA_WIDTH-1:0] SEED_W     = DATA_WIDTH'(SEED);
    localparam logic [DATA_WIDTH-1:0] WALK_INIT  = DATA_WIDTH'(1);
    localparam logic [TMR_WIDTH-1:0]  TMR_LAST   = TMR_WIDTH'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_GAP,
        S_RD_REQ,
        S_RD_WAIT,
        S_DONE
    } state_t;

    // The walking-one pattern is carried in walk_q and rotated on every
    // index step, which avoids a modulo-DATA_WIDTH divider on the index.
    function automatic logic [DATA_WIDTH-1:0] pattern_of(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] walk,
        input logic [1:0]            sel
    );
        logic [ADDR_WIDTH-1:0] na;
        na = ~a;
        case (sel)
            2'd0:    return DATA_WIDTH'(a);
            2'd1:    return DATA_WIDTH'(na);
            2'd2:    return walk;
            default: return DATA_WIDTH'(a) ^ SEED_W;
        endcase
    endfunction

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] idx_q,   idx_d;
    logic [COUNT_WIDTH-1:0] cnt_q,   cnt_d;
    logic [ADDR_WIDTH-1:0]  base_q,  base_d;
    logic [1:0]             pat_q,   pat_d;
    logic [DATA_WIDTH-1:0]  walk_q,  walk_d;
    logic [TMR_WIDTH-1:0]   timer_q, timer_d;

    logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wr_q,    wr_d;
    logic                    rd_q,    rd_d;

    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic                   tmo_q,  tmo_d;
    logic [ERR_WIDTH-1:0]   err_q,  err_d;
    logic [ADDR_WIDTH-1:0]  fea_q,  fea_d;
    logic [DATA_WIDTH-1:0]  fed_q,  fed_d;

    logic                  is_last;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [DATA_WIDTH-1:0] walk_next;
    logic [DATA_WIDTH-1:0] expected;

    assign is_last   = (idx_q == cnt_q - COUNT_WIDTH'(1));
    assign addr_next = addr_q + STEP;
    assign walk_next = {walk_q[DATA_WIDTH-2:0], walk_q[DATA_WIDTH-1]};
    assign expected  = pattern_of(addr_q, walk_q, pat_q);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        pat_d   = pat_q;
        walk_d  = walk_q;
        timer_d = timer_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = '0;
        rd_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        fea_d   = fea_q;
        fed_d   = fed_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_addr & ALIGN_MASK;
                    cnt_d   = word_count;
                    pat_d   = pattern_sel;
                    idx_d   = '0;
                    walk_d  = WALK_INIT;
                    err_d   = '0;
                    fea_d   = '0;
                    fed_d   = '0;
                    tmo_d   = 1'b0;
                    pass_d  = 1'b0;
                    if (word_count == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = S_WR_REQ;
                        busy_d  = 1'b1;
                        wr_d    = '1;
                        addr_d  = base_addr & ALIGN_MASK;
                        wdata_d = pattern_of(base_addr & ALIGN_MASK,
                                             WALK_INIT, pattern_sel);
                    end
                end
            end

            S_WR_REQ: begin
                if (ctrl.rdy) state_d = S_WR_GAP;
                else          wr_d    = '1;
            end

            S_WR_GAP: begin
                if (is_last) begin
                    // Write phase finished: restart the sequence for reads.
                    state_d = S_RD_REQ;
                    idx_d   = '0;
                    addr_d  = base_q;
                    walk_d  = WALK_INIT;
                    rd_d    = 1'b1;
                end else begin
                    state_d = S_WR_REQ;
                    idx_d   = idx_q + COUNT_WIDTH'(1);
                    addr_d  = addr_next;
                    walk_d  = walk_next;
                    wdata_d = pattern_of(addr_next, walk_next, pat_q);
                    wr_d    = '1;
                end
            end

            S_RD_REQ: begin
                if (ctrl.rdy) begin
                    state_d = S_RD_WAIT;
                    timer_d = '0;
                end else begin
                    rd_d = 1'b1;
                end
            end

            S_RD_WAIT: begin
                if (ctrl.rvalid || timer_q == TMR_LAST) begin
                    if (!ctrl.rvalid || ctrl.read_data != expected) begin
                        // err_q is still zero only until the first error.
                        if (err_q == '0) begin
                            fea_d = addr_q;
                            fed_d = ctrl.rvalid ? ctrl.read_data : '0;
                        end
                        if (err_q != '1) err_d = err_q + ERR_WIDTH'(1);
                        if (!ctrl.rvalid) tmo_d = 1'b1;
                    end
                    if (is_last) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        pass_d  = (err_d == '0);
                    end else begin
                        state_d = S_RD_REQ;
                        idx_d   = idx_q + COUNT_WIDTH'(1);
                        addr_d  = addr_next;
                        walk_d  = walk_next;
                        rd_d    = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + TMR_WIDTH'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            base_q  <= '0;
            pat_q   <= '0;
            walk_q  <= WALK_INIT;
            timer_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= '0;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            tmo_q   <= 1'b0;
            err_q   <= '0;
            fea_q   <= '0;
            fed_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            pat_q   <= pat_d;
            walk_q  <= walk_d;
            timer_q <= timer_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            fea_q   <= fea_d;
            fed_q   <= fed_d;
        end
    end

    assign ctrl.addr       = addr_q;
    assign ctrl.write_data = wdata_q;
    assign ctrl.wr         = wr_q;
    assign ctrl.rd         = rd_q;

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = tmo_q;
    assign err_count      = err_q;
    assign first_err_addr = fea_q;
    assign first_err_data = fed_q;

endmodule

// File: tb/tb_sdram_bist.sv
// tb_sdram_bist: directed self-checking bench for sdram_bist.
// A behavioural responder stands in for sdram_core: a small word memory,
// controllable rdy, fixed read latency, optional bit-3 fault at one address
// and optional dropped response at one address.
`timescale 1ns/1ps
module tb_sdram_bist;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int CW     = 16;
    localparam int EW     = 16;
    localparam int TMO    = 64;
    localparam int RD_LAT = 2;
    localparam logic [31:0] NONE = 32'h0000_0001; // unaligned, never hit

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] word_count;
    logic [1:0]    pattern_sel;
    logic          busy, done, pass, timeout;
    logic [EW-1:0] err_count;
    logic [AW-1:0] first_err_addr;
    logic [DW-1:0] first_err_data;

    sdram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sdram_bist #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .COUNT_WIDTH(CW),
        .ERR_WIDTH  (EW),
        .SEED       (32'hA5A5_5A5A),
        .RD_TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .word_count    (word_count),
        .pattern_sel   (pattern_sel),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_addr(first_err_addr),
        .first_err_data(first_err_data),
        .timeout       (timeout),
        .ctrl          (bus)
    );

    always #5 clk = ~clk;

    // ---------------- responder ----------------
    logic          rdy_en;
    logic [31:0]   fault_addr, drop_addr;
    logic [31:0]   mem [0:255];
    logic          pend;
    int            lat;
    logic [31:0]   raddr;
    logic          rvalid_r;
    logic [31:0]   rdata_r;
    logic [31:0]   wlog_addr[$];
    logic [31:0]   wlog_data[$];
    int            wr_cycles, rd_cycles;

    assign bus.rdy       = rdy_en;
    assign bus.rvalid    = rvalid_r;
    assign bus.read_data = rdata_r;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        pend = 1'b0; lat = 0; raddr = '0; rvalid_r = 1'b0; rdata_r = '0;
        wr_cycles = 0; rd_cycles = 0;
    end

    always @(posedge clk) begin
        rvalid_r <= 1'b0;
        if (bus.wr != '0) wr_cycles <= wr_cycles + 1;
        if (bus.rd)       rd_cycles <= rd_cycles + 1;
        if (rst) begin
            pend <= 1'b0;
        end else begin
            if (bus.wr != '0 && rdy_en) begin
                mem[bus.addr[9:2]] <= bus.write_data;
                wlog_addr.push_back(bus.addr);
                wlog_data.push_back(bus.write_data);
            end
            if (pend) begin
                if (lat == 0) begin
                    pend <= 1'b0;
                    if (raddr != drop_addr) begin
                        rvalid_r <= 1'b1;
                        rdata_r  <= mem[raddr[9:2]] ^
                                    ((raddr == fault_addr) ? 32'h8 : 32'h0);
                    end
                end else begin
                    lat <= lat - 1;
                end
            end else if (bus.rd && rdy_en) begin
                pend  <= 1'b1;
                lat   <= RD_LAT;
                raddr <= bus.addr;
            end
        end
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [31:0] exp_a [0:3];
    logic [31:0] exp_d [0:3];

    task automatic check_wlog(input string tag, input int n);
        check({tag, "_nwr"}, 64'(wlog_addr.size()), 64'(n));
        if (wlog_addr.size() == n) begin
            for (int i = 0; i < n; i++) begin
                check($sformatf("%s_a%0d", tag, i), 64'(wlog_addr[i]), 64'(exp_a[i]));
                check($sformatf("%s_d%0d", tag, i), 64'(wlog_data[i]), 64'(exp_d[i]));
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_pass"}, 64'(pass), 64'd0);
        check({tag, "_tmo"},  64'(timeout), 64'd0);
        check({tag, "_err"},  64'(err_count), 64'd0);
        check({tag, "_fea"},  64'(first_err_addr), 64'd0);
        check({tag, "_fed"},  64'(first_err_data), 64'd0);
        check({tag, "_wr"},   64'(bus.wr), 64'd0);
        check({tag, "_rd"},   64'(bus.rd), 64'd0);
        check({tag, "_addr"}, 64'(bus.addr), 64'd0);
        check({tag, "_wdat"}, 64'(bus.write_data), 64'd0);
    endtask

    // Leaves the bench at the negedge following the edge that sampled start.
    task automatic do_start(input logic [31:0] b, input logic [15:0] n,
                            input logic [1:0] p);
        @(negedge clk);
        base_addr = b; word_count = n; pattern_sel = p; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic clear_log();
        wlog_addr.delete();
        wlog_data.delete();
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, r0, ndone, stable;
        logic [31:0] a0, d0;
        logic [3:0]  be0;

        rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
        pattern_sel = '0; rdy_en = 1'b1; fault_addr = NONE; drop_addr = NONE;
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        rst = 1'b0;

        // Clean run, pattern 0.
        clear_log();
        do_start(32'h100, 16'd4, 2'd0);
        check("clean_busy_n1", 64'(busy), 64'd1);
        check("clean_wr_n1", 64'(bus.wr), 64'hF);
        check("clean_addr_n1", 64'(bus.addr), 64'h100);
        wait_done("clean", 200);
        check("clean_busy_at_done", 64'(busy), 64'd0);
        check("clean_pass", 64'(pass), 64'd1);
        check("clean_err", 64'(err_count), 64'd0);
        check("clean_tmo", 64'(timeout), 64'd0);
        for (int i = 0; i < 4; i++) begin
            exp_a[i] = 32'h100 + 32'(4 * i);
            exp_d[i] = exp_a[i];
        end
        check_wlog("clean", 4);
        @(negedge clk);
        check("clean_done_pulse", 64'(done), 64'd0);
        check("clean_pass_hold", 64'(pass), 64'd1);

        // Fault injection: bit 3 flipped on the read of 0x108.
        fault_addr = 32'h108;
        do_start(32'h100, 16'd4, 2'd0);
        wait_done("fault", 200);
        check("fault_err", 64'(err_count), 64'd1);
        check("fault_fea", 64'(first_err_addr), 64'h108);
        check("fault_fed", 64'(first_err_data), 64'h100);
        check("fault_pass", 64'(pass), 64'd0);
        check("fault_tmo", 64'(timeout), 64'd0);
        fault_addr = NONE;

        // Zero count: done in the first cycle, no requests at all.
        w0 = wr_cycles; r0 = rd_cycles;
        do_start(32'h500, 16'd0, 2'd0);
        check("zero_done", 64'(done), 64'd1);
        check("zero_pass", 64'(pass), 64'd1);
        check("zero_busy", 64'(busy), 64'd0);
        check("zero_err", 64'(err_count), 64'd0);
        @(negedge clk);
        check("zero_done_pulse", 64'(done), 64'd0);
        repeat (5) @(negedge clk);
        check("zero_no_wr", 64'(wr_cycles - w0), 64'd0);
        check("zero_no_rd", 64'(rd_cycles - r0), 64'd0);

        // Busy lockout: a second start mid-run is ignored.
        clear_log();
        do_start(32'h200, 16'd4, 2'd0);
        repeat (3) @(negedge clk);
        do_start(32'h900, 16'd4, 2'd0);
        wait_done("lock", 200);
        check("lock_pass", 64'(pass), 64'd1);
        for (int i = 0; i < 4; i++) begin
            exp_a[i] = 32'h200 + 32'(4 * i);
            exp_d[i] = exp_a[i];
        end
        check_wlog("lock", 4);
        @(negedge clk);
        ndone = 0;
        for (int i = 0; i < 60; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("lock_no_second_run", 64'(ndone), 64'd0);
        check("lock_idle", 64'(busy), 64'd0);

        // Back-pressure on the first write, and address wrap through 0.
        clear_log();
        rdy_en = 1'b0;
        do_start(32'hFFFF_FFF8, 16'd4, 2'd0);
        a0 = bus.addr; d0 = bus.write_data; be0 = bus.wr;
        check("bp_first_addr", 64'(a0), 64'hFFFF_FFF8);
        stable = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.wr == be0 && be0 == 4'hF && bus.addr == a0 &&
                bus.write_data == d0) stable++;
            @(negedge clk);
        end
        check("bp_stable_cycles", 64'(stable), 64'd20);
        rdy_en = 1'b1;
        wait_done("bp", 200);
        check("bp_pass", 64'(pass), 64'd1);
        exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC;
        exp_a[2] = 32'h0;         exp_a[3] = 32'h4;
        for (int i = 0; i < 4; i++) exp_d[i] = exp_a[i];
        check_wlog("wrap", 4);

        // Pattern 1: inverted address.
        clear_log();
        do_start(32'h40, 16'd2, 2'd1);
        wait_done("pat1", 200);
        check("pat1_pass", 64'(pass), 64'd1);
        exp_a[0] = 32'h40; exp_d[0] = 32'hFFFF_FFBF;
        exp_a[1] = 32'h44; exp_d[1] = 32'hFFFF_FFBB;
        check_wlog("pat1", 2);

        // Pattern 2: walking one; base given unaligned on purpose.
        clear_log();
        do_start(32'h83, 16'd3, 2'd2);
        wait_done("pat2", 200);
        check("pat2_pass", 64'(pass), 64'd1);
        exp_a[0] = 32'h80; exp_d[0] = 32'h1;
        exp_a[1] = 32'h84; exp_d[1] = 32'h2;
        exp_a[2] = 32'h88; exp_d[2] = 32'h4;
        check_wlog("pat2", 3);

        // Pattern 3: address XOR seed.
        clear_log();
        do_start(32'h10, 16'd2, 2'd3);
        wait_done("pat3", 200);
        check("pat3_pass", 64'(pass), 64'd1);
        exp_a[0] = 32'h10; exp_d[0] = 32'hA5A5_5A4A;
        exp_a[1] = 32'h14; exp_d[1] = 32'hA5A5_5A4E;
        check_wlog("pat3", 2);

        // Timeout: the read of index 1 never gets rvalid.
        drop_addr = 32'h304;
        do_start(32'h300, 16'd3, 2'd0);
        wait_done("tmo", 600);
        check("tmo_flag", 64'(timeout), 64'd1);
        check("tmo_err", 64'(err_count), 64'd1);
        check("tmo_fea", 64'(first_err_addr), 64'h304);
        check("tmo_fed", 64'(first_err_data), 64'd0);
        check("tmo_pass", 64'(pass), 64'd0);
        drop_addr = NONE;

        // Reset while waiting for read data.
        do_start(32'h400, 16'd4, 2'd0);
        begin
            bit saw_rd;
            saw_rd = 1'b0;
            for (int i = 0; i < 100; i++) begin
                if (bus.rd) begin
                    saw_rd = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check("mid_saw_rd", 64'(saw_rd), 64'd1);
        end
        @(negedge clk);
        check("mid_in_rd_wait", 64'(bus.rd), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("mid");
        rst = 1'b0;
        w0 = wr_cycles; r0 = rd_cycles;
        ndone = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("mid_no_done", 64'(ndone), 64'd0);
        check("mid_no_wr", 64'(wr_cycles - w0), 64'd0);
        check("mid_no_rd", 64'(rd_cycles - r0), 64'd0);

        clear_log();
        do_start(32'h100, 16'd4, 2'd0);
        wait_done("rerun", 200);
        check("rerun_pass", 64'(pass), 64'd1);
        check("rerun_err", 64'(err_count), 64'd0);
        for (int i = 0; i < 4; i++) begin
            exp_a[i] = 32'h100 + 32'(4 * i);
            exp_d[i] = exp_a[i];
        end
        check_wlog("rerun", 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
